reg_file: RTL and testbench
===========================

# reg_file

Architectural register file with per-register rename tags for the out-of-order RV32I core. It answers the decoder's two combinational source-operand lookups with either a committed value or the ROB tag of the in-flight producer. It records a new rename tag whenever the decoder issues an instruction with a destination register. It retires values and clears tags on ROB commit, and drops every tag on a misprediction rollback.

## Interface
Parameters:
- DATA_W, 32, register data width
- ROB_POS_W, 4, ROB index width (16 entries); a tag is ROB_POS_W+1 bits, formatted {busy, pos}
- REG_POS_W, 5, register index width (32 registers)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; when low, no state changes
- rollback  in  1  misprediction flush from ROB
- issue  in  1  decoder issues an instruction this cycle
- issue_rd  in  REG_POS_W  destination of the issued instruction
- issue_rob_pos  in  ROB_POS_W  ROB slot allocated to it
- reg_rs1  in  REG_POS_W  source-1 query index
- reg_rs1_val  out  DATA_W  source-1 value
- reg_rs1_rob_id  out  ROB_POS_W+1  source-1 tag; bit[ROB_POS_W]=0 means the value is valid
- reg_rs2, reg_rs2_val, reg_rs2_rob_id: same as rs1, for source 2
- commit  in  1  ROB retires an instruction this cycle
- commit_rd  in  REG_POS_W  its destination
- commit_val  in  DATA_W  its result
- commit_rob_pos  in  ROB_POS_W  its ROB slot

## Operation
- State: val[0..31] (DATA_W each) and tag[0..31] (busy bit + ROB_POS_W pos).
- Read ports are purely combinational from the current state, commit inputs, and query index:
  - x0 always reads val 0, rob_id 0.
  - If commit && commit_rd==q && commit_rd!=0 && tag[q]=={1,commit_rob_pos}: return commit_val with rob_id 0 (commit forwarding).
  - Else if tag[q] is busy: return val 0 and rob_id tag[q].
  - Else: return val[q] with rob_id 0.
  - Reads never see the same-cycle issue. An instruction whose rd equals its own rs (e.g. addi x1,x1,1) gets the old mapping. The read outputs must not depend combinationally on issue*; this prevents a loop through the decoder.
- Update at the clock edge, only when rdy=1 and rst=0:
  - Commit (commit && commit_rd!=0): val[commit_rd] <= commit_val. Tag cleared only if tag[commit_rd]=={1,commit_rob_pos}; otherwise a younger rename stays.
  - Issue (issue && issue_rd!=0 && !rollback): tag[issue_rd] <= {1,issue_rob_pos}. Issue wins over a same-cycle commit clear of the same register.
  - Rollback: all 32 tags <= 0, and issue is ignored. A same-cycle commit still writes its value.
- Writes and renames to x0 are always discarded. val[0] and tag[0] stay 0.

## Timing
- Reset (asynchronous, immediate): all val=0 and all tag=0. Every read output is therefore 0/0 while rst is high and after it deasserts.
- Read latency: 0 cycles (combinational).
- Write latency: 1 cycle. A committed value is visible through state on the cycle after commit, and through forwarding in the commit cycle itself.
- A tag written at edge N is visible to queries from cycle N onward.
- rdy=0: state frozen; reads remain live and reflect frozen state plus commit forwarding.
- rst asserted mid-operation overrides everything in that cycle. Pending commits and issues are lost.

## Test plan
- Reset, then query rs1=5, rs2=0 -> val 0, rob_id 0 on both.
- Issue rd=3 with rob_pos=7, then query rs1=3 next cycle -> rob_id 5'b10111, val 0. Commit rd=3, pos 7, val 0xDEADBEEF, querying x3 in the same cycle -> 0xDEADBEEF with rob_id 0. Next cycle -> same value from state.
- Rename x4 to pos 2, then rename x4 to pos 9. Commit x4 from pos 2 with val 0x11 -> val[4]=0x11, tag stays 5'b11001; query returns rob_id 5'b11001.
- In the same cycle, commit x6 from pos 1 (its current tag) and issue rd=6 at pos 4 -> tag[6]=5'b10100, val[6]=commit value. A same-cycle query of x6 returns the forwarded commit value.
- Rename x1, x2, x31. Assert rollback together with issue rd=8 and commit x1 with val 0x55 -> all tags 0, x8 not renamed, val[1]=0x55.
- Issue rd=0 at pos 3 and commit rd=0 with val 0xFF -> x0 still reads 0/0. With rdy=0, issue rd=9 -> no tag change.

Source files
------------

// File: rtl/reg_file_if.sv
// Decoder/ROB-facing bundle of the architectural register file.
// The master side (decoder + ROB) drives issue, commit and queries; the slave side answers.
interface reg_file_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ROB_POS_W = 4,
    parameter int unsigned REG_POS_W = 5
);
    logic                   rdy;
    logic                   rollback;

    logic                   issue;
    logic [REG_POS_W-1:0]   issue_rd;
    logic [ROB_POS_W-1:0]   issue_rob_pos;

    logic [REG_POS_W-1:0]   reg_rs1;
    logic [DATA_W-1:0]      reg_rs1_val;
    logic [ROB_POS_W:0]     reg_rs1_rob_id;
    logic [REG_POS_W-1:0]   reg_rs2;
    logic [DATA_W-1:0]      reg_rs2_val;
    logic [ROB_POS_W:0]     reg_rs2_rob_id;

    logic                   commit;
    logic [REG_POS_W-1:0]   commit_rd;
    logic [DATA_W-1:0]      commit_val;
    logic [ROB_POS_W-1:0]   commit_rob_pos;

    modport master (
        output rdy, rollback,
        output issue, issue_rd, issue_rob_pos,
        output reg_rs1, reg_rs2,
        output commit, commit_rd, commit_val, commit_rob_pos,
        input  reg_rs1_val, reg_rs1_rob_id, reg_rs2_val, reg_rs2_rob_id
    );

    modport slave (
        input  rdy, rollback,
        input  issue, issue_rd, issue_rob_pos,
        input  reg_rs1, reg_rs2,
        input  commit, commit_rd, commit_val, commit_rob_pos,
        output reg_rs1_val, reg_rs1_rob_id, reg_rs2_val, reg_rs2_rob_id
    );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Reads return either a committed value or the busy ROB tag of the in-flight producer,
// with same-cycle commit forwarding. Issue renames, commit retires, rollback drops all tags.
module reg_file #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ROB_POS_W = 4,
    parameter int unsigned REG_POS_W = 5
) (
    input logic      clk,
    input logic      rst,
    reg_file_if.slave bus
);
    localparam int unsigned TagW    = ROB_POS_W + 1;
    localparam int unsigned NumRegs = 2 ** REG_POS_W;

    logic [DATA_W-1:0] val_q [NumRegs];
    logic [DATA_W-1:0] val_d [NumRegs];
    logic [TagW-1:0]   tag_q [NumRegs];
    logic [TagW-1:0]   tag_d [NumRegs];

    logic              commit_en;
    logic [TagW-1:0]   commit_tag;

    logic [REG_POS_W-1:0] rs_idx [2];
    logic [DATA_W-1:0]    rd_val [2];
    logic [TagW-1:0]      rd_tag [2];

    assign commit_en  = bus.commit && (bus.commit_rd != '0);
    assign commit_tag = {1'b1, bus.commit_rob_pos};

    // Next state: commit writes value and clears a matching tag; issue renames on top of that,
    // so a same-cycle issue to the same register keeps the new tag. Rollback drops every tag.
    always_comb begin
        val_d = val_q;
        tag_d = tag_q;
        if (commit_en) begin
            val_d[bus.commit_rd] = bus.commit_val;
            // Only the producer that owns the current mapping may clear it.
            if (tag_q[bus.commit_rd] == commit_tag) begin
                tag_d[bus.commit_rd] = '0;
            end
        end
        if (bus.rollback) begin
            for (int i = 0; i < NumRegs; i++) begin
                tag_d[i] = '0;
            end
        end else if (bus.issue && (bus.issue_rd != '0)) begin
            tag_d[bus.issue_rd] = {1'b1, bus.issue_rob_pos};
        end
    end

    // State registers: cleared asynchronously, frozen while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (bus.rdy) begin
            val_q <= val_d;
            tag_q <= tag_d;
        end
    end

    assign rs_idx[0] = bus.reg_rs1;
    assign rs_idx[1] = bus.reg_rs2;

    // Read ports: current state plus commit forwarding; deliberately independent of issue*.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = '0;
            rd_tag[p] = '0;
            if (rs_idx[p] != '0) begin
                if (commit_en && (bus.commit_rd == rs_idx[p]) &&
                    (tag_q[rs_idx[p]] == commit_tag)) begin
                    rd_val[p] = bus.commit_val;
                end else if (tag_q[rs_idx[p]][ROB_POS_W]) begin
                    rd_tag[p] = tag_q[rs_idx[p]];
                end else begin
                    rd_val[p] = val_q[rs_idx[p]];
                end
            end
        end
    end

    assign bus.reg_rs1_val    = rd_val[0];
    assign bus.reg_rs1_rob_id = rd_tag[0];
    assign bus.reg_rs2_val    = rd_val[1];
    assign bus.reg_rs2_rob_id = rd_tag[1];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against a
// behavioural model of committed values and rename mappings.
module tb_reg_file;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ROB_POS_W = 4;
    localparam int unsigned REG_POS_W = 5;

    logic clk;
    logic rst;

    int checks;
    int failures;

    reg_file_if #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W), .REG_POS_W(REG_POS_W)) bus ();

    reg_file #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W), .REG_POS_W(REG_POS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: committed value per register and current rename (busy + ROB slot).
    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [3:0]  m_pos  [32];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_pos[i]  = '0;
        end
    endtask

    // Apply the edge rules using the inputs currently on the bus.
    task automatic model_update();
        if (rst) begin
            model_reset();
        end else if (bus.rdy) begin
            int cr;
            int ir;
            cr = int'(bus.commit_rd);
            ir = int'(bus.issue_rd);
            if (bus.commit && cr != 0) begin
                m_val[cr] = bus.commit_val;
                if (m_busy[cr] && m_pos[cr] == bus.commit_rob_pos) m_busy[cr] = 1'b0;
            end
            if (bus.rollback) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (bus.issue && ir != 0) begin
                m_busy[ir] = 1'b1;
                m_pos[ir]  = bus.issue_rob_pos;
            end
        end
    endtask

    task automatic model_read(input logic [4:0] q, output logic [31:0] v, output logic [4:0] id);
        int qi;
        qi = int'(q);
        v  = '0;
        id = '0;
        if (qi == 0) begin
            v = '0;
        end else if (bus.commit && bus.commit_rd == q && m_busy[qi] &&
                     m_pos[qi] == bus.commit_rob_pos) begin
            v = bus.commit_val;
        end else if (m_busy[qi]) begin
            id = {1'b1, m_pos[qi]};
        end else begin
            v = m_val[qi];
        end
    endtask

    task automatic drive_idle();
        bus.rdy            = 1'b1;
        bus.rollback       = 1'b0;
        bus.issue          = 1'b0;
        bus.issue_rd       = '0;
        bus.issue_rob_pos  = '0;
        bus.reg_rs1        = '0;
        bus.reg_rs2        = '0;
        bus.commit         = 1'b0;
        bus.commit_rd      = '0;
        bus.commit_val     = '0;
        bus.commit_rob_pos = '0;
    endtask

    // Advance one clock; model follows the edge, then inputs may change at posedge+1.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
        drive_idle();
        bus.issue         = 1'b1;
        bus.issue_rd      = rd;
        bus.issue_rob_pos = pos;
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        drive_idle();
        bus.reg_rs1 = 5'd5;
        bus.reg_rs2 = 5'd0;
        #2;
        checks++;
        if (bus.reg_rs1_val !== 32'h0 || bus.reg_rs1_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL reset_rs1_in_reset got %h/%b want 0/0", bus.reg_rs1_val, bus.reg_rs1_rob_id);
        end
        checks++;
        if (bus.reg_rs2_val !== 32'h0 || bus.reg_rs2_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL reset_rs2_in_reset got %h/%b want 0/0", bus.reg_rs2_val, bus.reg_rs2_rob_id);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (bus.reg_rs1_val !== 32'h0 || bus.reg_rs1_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL reset_rs1_after got %h/%b want 0/0", bus.reg_rs1_val, bus.reg_rs1_rob_id);
        end
        checks++;
        if (bus.reg_rs2_val !== 32'h0 || bus.reg_rs2_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL reset_rs2_after got %h/%b want 0/0", bus.reg_rs2_val, bus.reg_rs2_rob_id);
        end
    endtask

    task automatic test_rename_commit();
        do_issue(5'd3, 4'd7);
        bus.reg_rs1 = 5'd3;
        #2;
        checks++;
        if (bus.reg_rs1_val !== 32'h0 || bus.reg_rs1_rob_id !== 5'b10111) begin
            failures++;
            $display("FAIL rename_x3 got %h/%b want 0/10111", bus.reg_rs1_val, bus.reg_rs1_rob_id);
        end
        bus.commit         = 1'b1;
        bus.commit_rd      = 5'd3;
        bus.commit_rob_pos = 4'd7;
        bus.commit_val     = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.reg_rs1_val !== 32'hDEADBEEF || bus.reg_rs1_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL commit_fwd_x3 got %h/%b want deadbeef/0", bus.reg_rs1_val, bus.reg_rs1_rob_id);
        end
        tick();
        drive_idle();
        bus.reg_rs1 = 5'd3;
        #2;
        checks++;
        if (bus.reg_rs1_val !== 32'hDEADBEEF || bus.reg_rs1_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL commit_state_x3 got %h/%b want deadbeef/0", bus.reg_rs1_val, bus.reg_rs1_rob_id);
        end
    endtask

    task automatic test_younger_rename();
        do_issue(5'd4, 4'd2);
        do_issue(5'd4, 4'd9);
        bus.commit         = 1'b1;
        bus.commit_rd      = 5'd4;
        bus.commit_rob_pos = 4'd2;
        bus.commit_val     = 32'h11;
        bus.reg_rs2        = 5'd4;
        #2;
        checks++;
        if (bus.reg_rs2_val !== 32'h0 || bus.reg_rs2_rob_id !== 5'b11001) begin
            failures++;
            $display("FAIL stale_commit_no_fwd got %h/%b want 0/11001", bus.reg_rs2_val, bus.reg_rs2_rob_id);
        end
        tick();
        drive_idle();
        bus.reg_rs2 = 5'd4;
        #2;
        checks++;
        if (bus.reg_rs2_val !== 32'h0 || bus.reg_rs2_rob_id !== 5'b11001) begin
            failures++;
            $display("FAIL younger_tag_kept got %h/%b want 0/11001", bus.reg_rs2_val, bus.reg_rs2_rob_id);
        end
    endtask

    task automatic test_commit_issue_same();
        do_issue(5'd6, 4'd1);
        bus.commit         = 1'b1;
        bus.commit_rd      = 5'd6;
        bus.commit_rob_pos = 4'd1;
        bus.commit_val     = 32'hA5A5_0606;
        bus.issue          = 1'b1;
        bus.issue_rd       = 5'd6;
        bus.issue_rob_pos  = 4'd4;
        bus.reg_rs1        = 5'd6;
        #2;
        checks++;
        if (bus.reg_rs1_val !== 32'hA5A5_0606 || bus.reg_rs1_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL same_cycle_fwd_x6 got %h/%b want a5a50606/0", bus.reg_rs1_val, bus.reg_rs1_rob_id);
        end
        tick();
        drive_idle();
        bus.reg_rs1 = 5'd6;
        #2;
        checks++;
        if (bus.reg_rs1_val !== 32'h0 || bus.reg_rs1_rob_id !== 5'b10100) begin
            failures++;
            $display("FAIL issue_wins_x6 got %h/%b want 0/10100", bus.reg_rs1_val, bus.reg_rs1_rob_id);
        end
    endtask

    task automatic test_rollback();
        logic [4:0]  qs [5];
        logic [31:0] ev [5];
        qs = '{5'd1, 5'd8, 5'd4, 5'd6, 5'd31};
        ev = '{32'h55, 32'h0, 32'h11, 32'hA5A5_0606, 32'h0};
        do_issue(5'd1, 4'd3);
        do_issue(5'd2, 4'd5);
        do_issue(5'd31, 4'd6);
        bus.rollback       = 1'b1;
        bus.issue          = 1'b1;
        bus.issue_rd       = 5'd8;
        bus.issue_rob_pos  = 4'd10;
        bus.commit         = 1'b1;
        bus.commit_rd      = 5'd1;
        bus.commit_rob_pos = 4'd3;
        bus.commit_val     = 32'h55;
        tick();
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            bus.reg_rs1 = qs[i];
            #1;
            checks++;
            if (bus.reg_rs1_val !== ev[i] || bus.reg_rs1_rob_id !== 5'h0) begin
                failures++;
                $display("FAIL rollback_x%0d got %h/%b want %h/0", qs[i], bus.reg_rs1_val,
                         bus.reg_rs1_rob_id, ev[i]);
            end
        end
    endtask

    task automatic test_x0_and_rdy();
        bus.issue          = 1'b1;
        bus.issue_rd       = 5'd0;
        bus.issue_rob_pos  = 4'd3;
        bus.commit         = 1'b1;
        bus.commit_rd      = 5'd0;
        bus.commit_val     = 32'hFF;
        bus.reg_rs1        = 5'd0;
        #2;
        checks++;
        if (bus.reg_rs1_val !== 32'h0 || bus.reg_rs1_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL x0_same_cycle got %h/%b want 0/0", bus.reg_rs1_val, bus.reg_rs1_rob_id);
        end
        tick();
        drive_idle();
        #2;
        checks++;
        if (bus.reg_rs1_val !== 32'h0 || bus.reg_rs1_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL x0_after got %h/%b want 0/0", bus.reg_rs1_val, bus.reg_rs1_rob_id);
        end
        bus.rdy           = 1'b0;
        bus.issue         = 1'b1;
        bus.issue_rd      = 5'd9;
        bus.issue_rob_pos = 4'd5;
        tick();
        drive_idle();
        bus.reg_rs2 = 5'd9;
        #2;
        checks++;
        if (bus.reg_rs2_val !== 32'h0 || bus.reg_rs2_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL rdy_low_frozen got %h/%b want 0/0", bus.reg_rs2_val, bus.reg_rs2_rob_id);
        end
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        logic [31:0] ev;
        logic [4:0]  eid;
        int          cr;
        for (int c = 0; c < 400; c++) begin
            bus.rdy           = ($urandom_range(0, 9) != 0);
            bus.rollback      = ($urandom_range(0, 24) == 0);
            bus.issue         = 1'($urandom_range(0, 1));
            bus.issue_rd      = pick_reg();
            bus.issue_rob_pos = 4'($urandom);
            bus.commit        = 1'($urandom_range(0, 1));
            bus.commit_rd     = pick_reg();
            bus.commit_val    = $urandom;
            cr = int'(bus.commit_rd);
            // Mostly commit the current producer so forwarding and tag clears get exercised.
            if (m_busy[cr] && $urandom_range(0, 3) != 0) bus.commit_rob_pos = m_pos[cr];
            else bus.commit_rob_pos = 4'($urandom);
            bus.reg_rs1 = ($urandom_range(0, 2) == 0) ? bus.commit_rd : pick_reg();
            bus.reg_rs2 = pick_reg();
            #2;
            model_read(bus.reg_rs1, ev, eid);
            checks++;
            if (bus.reg_rs1_val !== ev || bus.reg_rs1_rob_id !== eid) begin
                failures++;
                $display("FAIL rand_rs1 cyc=%0d x%0d got %h/%b want %h/%b", c, bus.reg_rs1,
                         bus.reg_rs1_val, bus.reg_rs1_rob_id, ev, eid);
            end
            model_read(bus.reg_rs2, ev, eid);
            checks++;
            if (bus.reg_rs2_val !== ev || bus.reg_rs2_rob_id !== eid) begin
                failures++;
                $display("FAIL rand_rs2 cyc=%0d x%0d got %h/%b want %h/%b", c, bus.reg_rs2,
                         bus.reg_rs2_val, bus.reg_rs2_rob_id, ev, eid);
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        do_issue(5'd10, 4'd1);
        bus.issue          = 1'b1;
        bus.issue_rd       = 5'd11;
        bus.issue_rob_pos  = 4'd2;
        bus.commit         = 1'b1;
        bus.commit_rd      = 5'd10;
        bus.commit_rob_pos = 4'd1;
        bus.commit_val     = 32'h77;
        bus.reg_rs1        = 5'd10;
        bus.reg_rs2        = 5'd11;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.reg_rs2_val !== 32'h0 || bus.reg_rs2_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL async_reset_x11 got %h/%b want 0/0", bus.reg_rs2_val, bus.reg_rs2_rob_id);
        end
        tick();
        rst = 1'b0;
        drive_idle();
        bus.reg_rs1 = 5'd10;
        bus.reg_rs2 = 5'd3;
        #2;
        checks++;
        if (bus.reg_rs1_val !== 32'h0 || bus.reg_rs1_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL reset_drops_commit_x10 got %h/%b want 0/0", bus.reg_rs1_val, bus.reg_rs1_rob_id);
        end
        checks++;
        if (bus.reg_rs2_val !== 32'h0 || bus.reg_rs2_rob_id !== 5'h0) begin
            failures++;
            $display("FAIL reset_clears_x3 got %h/%b want 0/0", bus.reg_rs2_val, bus.reg_rs2_rob_id);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        test_reset();
        test_rename_commit();
        test_younger_rename();
        test_commit_issue_same();
        test_rollback();
        test_x0_and_rdy();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
